// File: rtl/cpu_pkg.sv
// Shared core definitions: sequencer states, reset/halt constants, jump opcodes.
package cpu_pkg;

    localparam int PC_W = 15;
    localparam int CNT_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = 15'd0;
    localparam logic [5:0] HALT_OP = 6'b111111;

    localparam logic [5:0] OP_J   = 6'b011000;
    localparam logic [5:0] OP_JR  = 6'b011001;
    localparam logic [5:0] OP_JAL = 6'b011010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Host/core-facing bundle of the run sequencer.
// Breakpoint signals exist only with CPU_SEQ_BREAKPOINT_EN.
interface cpu_sequencer_if
    import cpu_pkg::*;
#(
    parameter int PC_W_P = PC_W,
    parameter int CNT_W_P = CNT_W
);
    logic start;
    logic halt_req;
    logic step;
    logic [5:0] opcode;
    logic PC_control;
    logic [PC_W_P-1:0] j_instr_addr;
    logic [PC_W_P-1:0] PC;
    logic core_en;
    logic busy;
    logic halted;
    logic retire;
    logic [CNT_W_P-1:0] cycle_count;
    logic [CNT_W_P-1:0] instr_count;
`ifdef CPU_SEQ_BREAKPOINT_EN
    logic bp_valid;
    logic [PC_W_P-1:0] bp_addr;
`endif

    modport master (
        output start, halt_req, step, opcode,
        output PC_control, j_instr_addr,
`ifdef CPU_SEQ_BREAKPOINT_EN
        output bp_valid, bp_addr,
`endif
        input PC, core_en, busy, halted, retire,
        input cycle_count, instr_count
    );

    modport slave (
        input start, halt_req, step, opcode,
        input PC_control, j_instr_addr,
`ifdef CPU_SEQ_BREAKPOINT_EN
        input bp_valid, bp_addr,
`endif
        output PC, core_en, busy, halted, retire,
        output cycle_count, instr_count
    );

endinterface

// File: rtl/cpu_sequencer_perf_counter.sv
// Width-parameterised wrapping event counter with synchronous clear.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Two-phase run controller owning the PC; gates core commits via core_en.
// Optional PC breakpoint: define CPU_SEQ_BREAKPOINT_EN.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W_P = PC_W,
    parameter logic [PC_W_P-1:0] RESET_PC_P = RESET_PC,
    parameter logic [5:0] HALT_OP_P = HALT_OP,
    parameter int CNT_W_P = CNT_W
) (
    input logic clk,
    input logic rst,
    cpu_sequencer_if.slave bus
);

    seq_state_t state_q, state_d;
    logic [PC_W_P-1:0] pc_q, pc_d;
    logic step_mode_q, step_mode_d;
    logic bp_skip_q, bp_skip_d;
    logic is_halt_op;
    logic commit;
    logic bp_hit;

    assign is_halt_op = (bus.opcode == HALT_OP_P);
    // rst blocks the commit of an in-flight EXEC cycle.
    assign commit = (state_q == EXEC) && !is_halt_op && !rst;

`ifdef CPU_SEQ_BREAKPOINT_EN
    assign bp_hit = bus.bp_valid && (pc_q == bus.bp_addr) && !bp_skip_q;
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        step_mode_d = step_mode_q;
        bp_skip_d = bp_skip_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = FETCH;
                    pc_d = RESET_PC_P;
                end
            end
            FETCH: begin
                if (bus.halt_req) begin
                    state_d = HALTED;
                end else if (bp_hit) begin
                    state_d = HALTED;
                    bp_skip_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_halt_op) begin
                    state_d = HALTED;
                end else begin
                    pc_d = bus.PC_control ? bus.j_instr_addr
                                          : pc_q + PC_W_P'(1);
                    bp_skip_d = 1'b0;
                    if (step_mode_q || bus.halt_req) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                if (bus.step) begin
                    state_d = FETCH;
                    step_mode_d = 1'b1;
                end else if (bus.start && !bus.halt_req) begin
                    state_d = FETCH;
                    step_mode_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q <= RESET_PC_P;
            step_mode_q <= 1'b0;
            bp_skip_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            step_mode_q <= step_mode_d;
            bp_skip_q <= bp_skip_d;
        end
    end

    assign bus.PC = pc_q;
    assign bus.core_en = commit;
    assign bus.retire = commit;
    assign bus.busy = (state_q == FETCH) || (state_q == EXEC);
    assign bus.halted = (state_q == HALTED);

    perf_counter #(.W(CNT_W_P)) u_cycle_cnt (
        .clk(clk),
        .rst(rst),
        .clr_i(1'b0),
        .en_i(bus.busy),
        .count_o(bus.cycle_count)
    );

    perf_counter #(.W(CNT_W_P)) u_instr_cnt (
        .clk(clk),
        .rst(rst),
        .clr_i(1'b0),
        .en_i(commit),
        .count_o(bus.instr_count)
    );

endmodule
